// File: rtl/gray_pointer_receiver_if.sv
// Link bundle between a gray-code writer (master) and the gray pointer receiver (slave).
interface gray_pointer_receiver_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] gray_in;
  logic             error_clear;
  logic [WIDTH-1:0] binary_out;
  logic             binary_valid;
  logic [WIDTH-1:0] delta;
  logic             step_error;

  modport master (
    output gray_in, error_clear,
    input  binary_out, binary_valid, delta, step_error
  );

  modport slave (
    input  gray_in, error_clear,
    output binary_out, binary_valid, delta, step_error
  );
endinterface

// File: rtl/gray_pointer_receiver.sv
// Synchronises a gray-coded pointer into clk, decodes it to binary and reports
// each change with a valid strobe, a modular delta and a sticky multi-bit-step error.
module gray_pointer_receiver #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  gray_pointer_receiver_if.slave  io_link
);

  localparam int FILL_W = $clog2(SYNC_STAGES + 1);

  typedef enum logic {PRIME, TRACK} state_t;

  state_t                            r_state;
  state_t                            w_state_next;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [FILL_W-1:0]                 r_fill;
  logic [FILL_W-1:0]                 w_fill_next;
  logic [WIDTH-1:0]                  r_prev_gray;
  logic [WIDTH-1:0]                  r_binary;
  logic [WIDTH-1:0]                  r_delta;
  logic                              r_valid;
  logic                              r_error;
  logic [WIDTH-1:0]                  w_sync_out;
  logic [WIDTH-1:0]                  w_sync_bin;
  logic [WIDTH-1:0]                  w_diff;
  logic                              w_load;
  logic                              w_change;
  logic                              w_set_error;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= io_link.gray_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  assign w_sync_out = r_sync[SYNC_STAGES-1];
  assign w_diff     = w_sync_out ^ r_prev_gray;

  // Binary bit i is the XOR of all gray bits at or above position i.
  always_comb begin
    w_sync_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_sync_bin[i] = ^(w_sync_out >> i);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= PRIME;
      r_fill  <= '0;
    end else begin
      r_state <= w_state_next;
      r_fill  <= w_fill_next;
    end
  end

  // Priming waits until the chain holds post-reset samples before the first load.
  always_comb begin
    w_state_next = r_state;
    w_fill_next  = r_fill;
    w_load       = 1'b0;
    w_change     = 1'b0;
    w_set_error  = 1'b0;
    case (r_state)
      PRIME: begin
        if (r_fill == FILL_W'(SYNC_STAGES)) begin
          w_load       = 1'b1;
          w_state_next = TRACK;
        end else begin
          w_fill_next = r_fill + FILL_W'(1);
        end
      end
      TRACK: begin
        if (w_sync_out != r_prev_gray) begin
          w_change    = 1'b1;
          w_set_error = (w_diff & (w_diff - WIDTH'(1))) != '0;
        end
      end
      default: w_state_next = PRIME;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_prev_gray <= '0;
      r_binary    <= '0;
      r_delta     <= '0;
      r_valid     <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_valid <= w_load | w_change;
      if (w_load || w_change) begin
        r_prev_gray <= w_sync_out;
        r_binary    <= w_sync_bin;
        r_delta     <= w_load ? '0 : (w_sync_bin - r_binary);
      end
      // A new illegal step wins over a clear requested in the same cycle.
      if (w_set_error) begin
        r_error <= 1'b1;
      end else if (io_link.error_clear) begin
        r_error <= 1'b0;
      end
    end
  end

  assign io_link.binary_out   = r_binary;
  assign io_link.binary_valid = r_valid;
  assign io_link.delta        = r_delta;
  assign io_link.step_error   = r_error;

endmodule
